banked_ram: RTL and testbench

BANKED_RAM -- requirements
Module: banked_ram

---
 rtl/banked_ram.sv | 229 ++++++++++++++++++++++
 tb/tb_banked_ram.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/banked_ram.sv
// banked_ram: byte-addressed RAM window with a fixed region and a
// switchable bank region, plus a memory-mapped bank-select register.
//
// Address map (defaults in brackets):
//   BASE_ADDR .. BASE_ADDR+BANK_BYTES-1               fixed bank 0   [C000-CFFF]
//   BASE_ADDR+BANK_BYTES .. BASE_ADDR+2*BANK_BYTES-1  bank bank_sel  [D000-DFFF]
//   BANK_REG_ADDR                                     bank register  [FF70]
//   everything else is unmapped (reads return OPEN_BUS).
//
// Ports:
//   clk       in   single clock, rising edge
//   rst       in   synchronous active-high reset
//   req       in   access request, accepted every cycle it is high and rst is low
//   we        in   1 = write, 0 = read
//   adr       in   byte address
//   data_in   in   write data
//   ack       out  one-cycle pulse the cycle after an accepted write
//   rvalid    out  one-cycle pulse READ_LAT cycles after an accepted read
//   data_out  out  read data, valid with rvalid, held until the next rvalid
//   hit       out  qualifies rvalid/ack: 1 = access mapped to RAM or bank register
//   bank_sel  out  current effective switchable bank (never 0)
//
// Handshake: there is no back-pressure. Every cycle with req=1 and rst=0
// accepts exactly one access. Writes complete at the accepting edge and are
// answered by ack one cycle later; reads are answered in order by rvalid
// exactly READ_LAT cycles after acceptance. With READ_LAT > 1 a read response
// and a write ack can land in the same cycle; hit then describes the read.
module banked_ram #(
  parameter int                DATA_W        = 8,
  parameter int                ADDR_W        = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR     = 16'hC000,
  parameter int                BANK_BYTES    = 4096,
  parameter int                NUM_BANKS     = 8,
  parameter int                READ_LAT      = 1,
  parameter logic [ADDR_W-1:0] BANK_REG_ADDR = 16'hFF70,
  parameter logic [DATA_W-1:0] OPEN_BUS      = 8'hFF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req,
  input  logic                         we,
  input  logic [ADDR_W-1:0]            adr,
  input  logic [DATA_W-1:0]            data_in,
  output logic                         ack,
  output logic                         rvalid,
  output logic [DATA_W-1:0]            data_out,
  output logic                         hit,
  output logic [$clog2(NUM_BANKS)-1:0] bank_sel
);

  localparam int BSEL_W    = $clog2(NUM_BANKS);
  localparam int MEM_DEPTH = NUM_BANKS * BANK_BYTES;
  localparam int MEM_AW    = $clog2(MEM_DEPTH);

  // Window bounds in 33-bit arithmetic so the window can never wrap
  // around the top of the address space into low addresses.
  localparam logic [32:0] WIN_LO  = 33'(BASE_ADDR);
  localparam logic [32:0] WIN_MID = WIN_LO + 33'(BANK_BYTES);
  localparam logic [32:0] WIN_HI  = WIN_MID + 33'(BANK_BYTES);

  // Parameter legality checks, reported at elaboration.
  if ((READ_LAT < 1) || (READ_LAT > 4)) begin : g_bad_read_lat
    $error("banked_ram: READ_LAT must be in 1..4");
  end
  if ((NUM_BANKS < 2) || (NUM_BANKS > 256) ||
      ((NUM_BANKS & (NUM_BANKS - 1)) != 0)) begin : g_bad_num_banks
    $error("banked_ram: NUM_BANKS must be a power of two in 2..256");
  end
  if (DATA_W < BSEL_W) begin : g_bad_data_w
    $error("banked_ram: DATA_W must hold the bank-select bits");
  end
  if (ADDR_W > 32) begin : g_bad_addr_w
    $error("banked_ram: ADDR_W must be at most 32");
  end

  // ---------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------
  logic              acc;
  logic [32:0]       adr_x;
  logic              is_breg;
  logic              in_fixed;
  logic              in_banked;
  logic              is_ram;
  logic [31:0]       off_x;
  logic [31:0]       bank_base;
  logic [MEM_AW-1:0] ram_idx;

  logic [BSEL_W-1:0] bank_q;
  logic [BSEL_W-1:0] bank_d;

  assign acc       = req & ~rst;
  assign adr_x     = 33'(adr);
  assign is_breg   = (adr == BANK_REG_ADDR);
  assign in_fixed  = !is_breg && (adr_x >= WIN_LO)  && (adr_x < WIN_MID);
  assign in_banked = !is_breg && (adr_x >= WIN_MID) && (adr_x < WIN_HI);
  assign is_ram    = in_fixed | in_banked;

  // A stored value of 0 selects bank 1: bank 0 is only reachable through
  // the fixed region.
  assign bank_sel = (bank_q == '0) ? BSEL_W'(1) : bank_q;

  always_comb begin
    off_x     = 32'(adr_x - WIN_LO);
    bank_base = 32'd0;
    if (in_banked) begin
      off_x     = 32'(adr_x - WIN_MID);
      bank_base = 32'(bank_sel) * 32'(BANK_BYTES);
    end
  end

  assign ram_idx = MEM_AW'(bank_base + off_x);

  // ---------------------------------------------------------------------
  // Bank-select register
  // ---------------------------------------------------------------------
  always_comb begin
    bank_d = bank_q;
    if (acc && we && is_breg) begin
      bank_d = data_in[BSEL_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_q <= BSEL_W'(1);
    end else begin
      bank_q <= bank_d;
    end
  end

  // ---------------------------------------------------------------------
  // Storage: not reset, so contents survive rst.
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] mem_q [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (acc && we && is_ram) begin
      mem_q[ram_idx] <= data_in;
    end
  end

  // ---------------------------------------------------------------------
  // Read source selection (captured into pipeline stage 0 on accept)
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] breg_rd;
  logic [DATA_W-1:0] rd_d;
  logic              rv_d;
  logic              rh_d;

  // Bank register reads back the stored bits with every upper bit set.
  always_comb begin
    breg_rd             = '1;
    breg_rd[BSEL_W-1:0] = bank_q;
  end

  always_comb begin
    rd_d = OPEN_BUS;
    if (is_breg) begin
      rd_d = breg_rd;
    end else if (is_ram) begin
      rd_d = mem_q[ram_idx];
    end
  end

  assign rv_d = acc & ~we;
  assign rh_d = is_breg | is_ram;

  // ---------------------------------------------------------------------
  // Read pipeline: READ_LAT stages, last stage drives the outputs. Data
  // registers only load behind a valid, so data_out holds between reads.
  // ---------------------------------------------------------------------
  logic [READ_LAT-1:0] rv_q;
  logic [READ_LAT-1:0] rh_q;
  logic [DATA_W-1:0]   rd_q [READ_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      rv_q <= '0;
      rh_q <= '0;
      for (int i = 0; i < READ_LAT; i++) begin
        rd_q[i] <= '0;
      end
    end else begin
      rv_q[0] <= rv_d;
      rh_q[0] <= rh_d;
      if (rv_d) begin
        rd_q[0] <= rd_d;
      end
      for (int i = 1; i < READ_LAT; i++) begin
        rv_q[i] <= rv_q[i-1];
        rh_q[i] <= rh_q[i-1];
        if (rv_q[i-1]) begin
          rd_q[i] <= rd_q[i-1];
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Write acknowledge
  // ---------------------------------------------------------------------
  logic ack_q;
  logic ack_d;
  logic wr_hit_q;
  logic wr_hit_d;

  assign ack_d    = acc & we;
  assign wr_hit_d = acc & we & (is_breg | is_ram);

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q    <= 1'b0;
      wr_hit_q <= 1'b0;
    end else begin
      ack_q    <= ack_d;
      wr_hit_q <= wr_hit_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign ack      = ack_q;
  assign rvalid   = rv_q[READ_LAT-1];
  assign data_out = rd_q[READ_LAT-1];
  assign hit      = rvalid ? rh_q[READ_LAT-1] : (ack_q & wr_hit_q);

endmodule

// File: tb/tb_banked_ram.sv
// Bench for banked_ram: two instances (READ_LAT 1 and 3) share one
// stimulus stream. A behavioural model predicts every output each cycle,
// and directed sequences pin known values with literal expectations.
module tb_banked_ram;

  // -------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [15:0] adr;
  logic [7:0]  data_in;

  logic       ack1, rv1, hit1;
  logic [7:0] dout1;
  logic [2:0] bsel1;
  logic       ack3, rv3, hit3;
  logic [7:0] dout3;
  logic [2:0] bsel3;

  always #5 clk = ~clk;

  banked_ram #(.READ_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .req(req), .we(we), .adr(adr), .data_in(data_in),
    .ack(ack1), .rvalid(rv1), .data_out(dout1), .hit(hit1), .bank_sel(bsel1)
  );

  banked_ram #(.READ_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .req(req), .we(we), .adr(adr), .data_in(data_in),
    .ack(ack3), .rvalid(rv3), .data_out(dout3), .hit(hit3), .bank_sel(bsel3)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------
  // Behavioural model: flat byte array, bank value, and a list of
  // pending responses tagged with the cycle they become visible.
  // -------------------------------------------------------------------
  typedef struct {
    int         dut;
    int         due;
    bit         rd;
    bit         hit;
    logic [7:0] data;
  } ev_t;

  logic [7:0] m_mem [32768];
  int         m_bank = 1;
  int         cyc = 0;
  bit         model_ok = 0;
  ev_t        evq[$];
  bit         e_ack [2];
  bit         e_rv  [2];
  bit         e_hit [2];
  logic [7:0] e_dout [2];

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic int eff_bank();
    return (m_bank == 0) ? 1 : m_bank;
  endfunction

  int         ma, midx;
  bit         m_reg, m_map, rh, wh;
  logic [7:0] m_rdat;
  ev_t        m_ev;

  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst) begin
      evq.delete();
      m_bank    = 1;
      e_dout[0] = 8'h00;
      e_dout[1] = 8'h00;
      model_ok  = 1;
    end else if (req) begin
      ma    = int'(adr);
      m_reg = (ma == 'hFF70);
      midx  = -1;
      if (!m_reg && ma >= 'hC000 && ma < 'hD000) midx = ma - 'hC000;
      else if (!m_reg && ma >= 'hD000 && ma < 'hE000) midx = eff_bank() * 4096 + (ma - 'hD000);
      m_map = m_reg || (midx >= 0);
      if (we) begin
        if (m_reg) m_bank = int'(data_in[2:0]);
        else if (midx >= 0) m_mem[midx] = data_in;
        m_rdat = 8'h00;
      end else begin
        if (m_reg) m_rdat = 8'hF8 | 8'(m_bank);
        else if (midx >= 0) m_rdat = m_mem[midx];
        else m_rdat = 8'hFF;
      end
      for (int k = 0; k < 2; k++) begin
        m_ev.dut  = k;
        m_ev.due  = we ? cyc : cyc + lat_of(k) - 1;
        m_ev.rd   = !we;
        m_ev.hit  = m_map;
        m_ev.data = m_rdat;
        evq.push_back(m_ev);
      end
    end
    for (int k = 0; k < 2; k++) begin
      e_ack[k] = 0;
      e_rv[k]  = 0;
      rh = 0;
      wh = 0;
      foreach (evq[i]) begin
        if (evq[i].dut == k && evq[i].due == cyc) begin
          if (evq[i].rd) begin
            e_rv[k]   = 1;
            rh        = evq[i].hit;
            e_dout[k] = evq[i].data;
          end else begin
            e_ack[k] = 1;
            wh       = evq[i].hit;
          end
        end
      end
      e_hit[k] = e_rv[k] ? rh : (e_ack[k] & wh);
    end
    for (int i = evq.size() - 1; i >= 0; i--) begin
      if (evq[i].due <= cyc) evq.delete(i);
    end
  end

  // -------------------------------------------------------------------
  // Scoreboard compare: every cycle, on the falling edge
  // -------------------------------------------------------------------
  initial forever begin
    @(negedge clk);
    if (model_ok) begin
      check("m_ack1",  32'(ack1),  32'(e_ack[0]));
      check("m_rv1",   32'(rv1),   32'(e_rv[0]));
      check("m_hit1",  32'(hit1),  32'(e_hit[0]));
      check("m_dout1", 32'(dout1), 32'(e_dout[0]));
      check("m_bsel1", 32'(bsel1), 32'(eff_bank()));
      check("m_ack3",  32'(ack3),  32'(e_ack[1]));
      check("m_rv3",   32'(rv3),   32'(e_rv[1]));
      check("m_hit3",  32'(hit3),  32'(e_hit[1]));
      check("m_dout3", 32'(dout3), 32'(e_dout[1]));
      check("m_bsel3", 32'(bsel3), 32'(eff_bank()));
    end
  end

  // -------------------------------------------------------------------
  // Driver tasks (called at a falling edge, return at the next one)
  // -------------------------------------------------------------------
  task automatic access(input bit w, input logic [15:0] a, input logic [7:0] d);
    req     = 1'b1;
    we      = w;
    adr     = a;
    data_in = d;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic idle(input int n);
    req = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [15:0] off_tab(input int i);
    return (i < 16) ? 16'(i) : 16'(4080 + i - 16);
  endfunction

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // -------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------
  logic [15:0] ra;
  int          r, s;

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; adr = '0; data_in = '0;
    repeat (3) @(negedge clk);
    check("rst_ack",  32'(ack1),  32'h0);
    check("rst_rv",   32'(rv1),   32'h0);
    check("rst_hit",  32'(hit1),  32'h0);
    check("rst_dout", 32'(dout1), 32'h0);
    check("rst_bsel", 32'(bsel1), 32'h1);
    rst = 1'b0;

    // Basic write / read
    access(1, 16'hC010, 8'h5A);
    check("w_ack", 32'(ack1), 32'h1);
    check("w_hit", 32'(hit1), 32'h1);
    access(0, 16'hC010, 8'h00);
    check("r_rv",   32'(rv1),   32'h1);
    check("r_data", 32'(dout1), 32'h5A);
    check("r_hit",  32'(hit1),  32'h1);

    // Bank switching
    access(1, 16'hFF70, 8'h02);
    access(1, 16'hD000, 8'h11);
    access(1, 16'hFF70, 8'h03);
    access(1, 16'hD000, 8'h22);
    access(1, 16'hFF70, 8'h02);
    access(0, 16'hD000, 8'h00);
    check("bank2_data", 32'(dout1), 32'h11);
    check("bank2_sel",  32'(bsel1), 32'h2);
    access(1, 16'hFF70, 8'h03);
    access(0, 16'hD000, 8'h00);
    check("bank3_data", 32'(dout1), 32'h22);

    // Bank register read-back
    access(1, 16'hFF70, 8'h00);
    check("bank0_sel", 32'(bsel1), 32'h1);
    access(0, 16'hFF70, 8'h00);
    check("breg_rd0", 32'(dout1), 32'hF8);
    access(1, 16'hFF70, 8'h05);
    access(0, 16'hFF70, 8'h00);
    check("breg_rd5", 32'(dout1), 32'hFD);
    check("bank5_sel", 32'(bsel1), 32'h5);

    // Unmapped accesses and window edges
    access(0, 16'h8000, 8'h00);
    check("open_rv",   32'(rv1),   32'h1);
    check("open_data", 32'(dout1), 32'hFF);
    check("open_hit",  32'(hit1),  32'h0);
    access(1, 16'h8000, 8'h33);
    check("unmap_ack", 32'(ack1), 32'h1);
    check("unmap_hit", 32'(hit1), 32'h0);
    access(0, 16'hC010, 8'h00);
    check("unmap_keep", 32'(dout1), 32'h5A);
    access(0, 16'hBFFF, 8'h00);
    check("below_data", 32'(dout1), 32'hFF);
    access(0, 16'hE000, 8'h00);
    check("above_hit", 32'(hit1), 32'h0);
    access(1, 16'hDFFF, 8'h77);
    access(1, 16'hCFFF, 8'h66);
    access(0, 16'hDFFF, 8'h00);
    check("top_banked", 32'(dout1), 32'h77);
    access(0, 16'hCFFF, 8'h00);
    check("top_fixed", 32'(dout1), 32'h66);

    // Pipelined reads on the READ_LAT=3 instance
    access(1, 16'hC000, 8'hA1);
    access(1, 16'hC001, 8'hB2);
    access(1, 16'hC002, 8'hC3);
    idle(3);
    access(0, 16'hC000, 8'h00);
    check("pipe_c1", 32'(rv3), 32'h0);
    access(0, 16'hC001, 8'h00);
    check("pipe_c2", 32'(rv3), 32'h0);
    access(0, 16'hC002, 8'h00);
    check("pipe_c3_rv", 32'(rv3),   32'h1);
    check("pipe_c3_d",  32'(dout3), 32'hA1);
    idle(1);
    check("pipe_c4_d", 32'(dout3), 32'hB2);
    idle(1);
    check("pipe_c5_d", 32'(dout3), 32'hC3);
    idle(1);
    check("pipe_c6_rv",   32'(rv3),   32'h0);
    check("pipe_c6_hold", 32'(dout3), 32'hC3);

    // Reset mid-read flushes the pipeline, keeps memory
    access(0, 16'hC001, 8'h00);
    rst = 1'b1;
    idle(1);
    check("flush_rv1",  32'(rv3),   32'h0);
    check("flush_dout", 32'(dout3), 32'h0);
    check("flush_bsel", 32'(bsel3), 32'h1);
    idle(1);
    check("flush_rv2", 32'(rv3), 32'h0);
    rst = 1'b0;
    access(0, 16'hC001, 8'h00);
    check("keep_d1", 32'(dout1), 32'hB2);
    idle(2);
    check("keep_rv3", 32'(rv3),   32'h1);
    check("keep_d3",  32'(dout3), 32'hB2);

    // Fill the offsets used by random traffic in every bank
    for (int i = 0; i < 32; i++) access(1, 16'hC000 + off_tab(i), 8'($urandom_range(0, 255)));
    for (int b = 1; b < 8; b++) begin
      access(1, 16'hFF70, 8'(b));
      for (int i = 0; i < 32; i++) access(1, 16'hD000 + off_tab(i), 8'($urandom_range(0, 255)));
    end

    // Randomized traffic
    for (int n = 0; n < 2500; n++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        rst     = 1'b1;
        req     = 1'($urandom_range(0, 1));
        we      = 1'($urandom_range(0, 1));
        adr     = 16'hC000 + off_tab($urandom_range(0, 31));
        data_in = 8'($urandom_range(0, 255));
        @(negedge clk);
        rst = 1'b0;
        req = 1'b0;
      end else if (r < 18) begin
        idle(1);
      end else begin
        s = $urandom_range(0, 9);
        case (s)
          0, 1, 2, 3: ra = 16'hC000 + off_tab($urandom_range(0, 31));
          4, 5, 6:    ra = 16'hD000 + off_tab($urandom_range(0, 31));
          7:          ra = 16'hFF70;
          8: begin
            case ($urandom_range(0, 5))
              0:       ra = 16'hBFFF;
              1:       ra = 16'hE000;
              2:       ra = 16'h0000;
              3:       ra = 16'hFFFF;
              4:       ra = 16'hFF6F;
              default: ra = 16'hFF71;
            endcase
          end
          default: ra = 16'($urandom_range(0, 'hBFFF));
        endcase
        access(1'($urandom_range(0, 1)), ra, 8'($urandom_range(0, 255)));
      end
    end
    idle(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
